// File: rtl/memory_access_sequencer_pkg.sv
// Shared types for the data-memory access sequencer.
// States, write-enable encoding and load/store funct3 codes.
package memory_access_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_READ,
    LOAD_CAPTURE,
    STORE_PRELOAD,
    STORE_WRITE
  } MemSeqState_t;

  typedef enum logic {
    WE_OFF = 1'b0,
    WE_ON  = 1'b1
  } WriteEnable_t;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

endpackage

// File: rtl/memory_access_checker.sv
// Combinational legality check for a load/store request.
// Flags illegal funct3, misalignment and out-of-range addresses.
module memory_access_checker
  import memory_access_sequencer_pkg::*;
#(
  parameter int unsigned RAM_A_WIDTH = 12
) (
  input  logic [2:0]  funct3,
  input  logic        isStore,
  input  logic [31:0] address,
  output logic        illegal,
  output logic        misaligned,
  output logic        outOfRange
);

  always_comb begin
    illegal = 1'b0;
    if (isStore) begin
      illegal = funct3 > FUNCT3_W;
    end else begin
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    end
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (funct3[1:0])
      2'b01:   misaligned = address[0];
      2'b10:   misaligned = |address[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign outOfRange = (address >> (RAM_A_WIDTH + 2)) != 32'd0;

endmodule

// File: rtl/memory_access_sequencer.sv
// Data-memory port initiator: one load/store at a time,
// with read-modify-write sequencing for sub-word stores.
module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
#(
  parameter int unsigned RAM_A_WIDTH = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reqValid,
  output logic         reqReady,
  input  logic         reqIsStore,
  input  logic [2:0]   reqFunct3,
  input  logic [31:0]  reqAddress,
  input  logic [31:0]  reqStoreData,
  output logic [31:0]  loadData,
  output logic         done,
  output logic         fault,
  output logic [2:0]   memFunct3,
  output logic [29:0]  memBackendAddress,
  output logic [1:0]   memOffset,
  output WriteEnable_t memWriteEnable,
  output logic [31:0]  memStoreData,
  input  logic [31:0]  memDataOut
);

  MemSeqState_t state_q, state_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  logic [31:0]  load_q, load_d;
  logic         done_q, done_d;
  logic         fault_q, fault_d;
  logic         illegal, misaligned, outOfRange;

  memory_access_checker #(
    .RAM_A_WIDTH(RAM_A_WIDTH)
  ) u_checker (
    .funct3     (reqFunct3),
    .isStore    (reqIsStore),
    .address    (reqAddress),
    .illegal    (illegal),
    .misaligned (misaligned),
    .outOfRange (outOfRange)
  );

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    data_d   = data_q;
    load_d   = load_q;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reqValid) begin
          funct3_d = reqFunct3;
          addr_d   = reqAddress;
          data_d   = reqStoreData;
          // Faulting requests never leave IDLE, so memory is untouched
          if (illegal || misaligned || outOfRange) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else if (!reqIsStore) begin
            state_d = LOAD_READ;
          end else if (reqFunct3 == FUNCT3_W) begin
            state_d = STORE_WRITE;
          end else begin
            state_d = STORE_PRELOAD;
          end
        end
      end
      LOAD_READ:     state_d = LOAD_CAPTURE;
      LOAD_CAPTURE: begin
        load_d  = memDataOut;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      STORE_PRELOAD: state_d = STORE_WRITE;
      STORE_WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default:       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      load_q   <= 32'd0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      load_q   <= load_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign reqReady          = state_q == IDLE;
  assign loadData          = load_q;
  assign done              = done_q;
  assign fault             = fault_q;
  assign memFunct3         = funct3_q;
  assign memBackendAddress = addr_q[31:2];
  assign memOffset         = addr_q[1:0];
  assign memStoreData      = data_q;
  assign memWriteEnable    = (state_q == STORE_WRITE) ? WE_ON : WE_OFF;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Bench for memory_access_sequencer with a big-endian RAM
// wrapper model and a done-driven scoreboard.
module tb_memory_access_sequencer;
  import memory_access_sequencer_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         reqValid;
  logic         reqReady;
  logic         reqIsStore;
  logic [2:0]   reqFunct3;
  logic [31:0]  reqAddress;
  logic [31:0]  reqStoreData;
  logic [31:0]  loadData;
  logic         done;
  logic         fault;
  logic [2:0]   memFunct3;
  logic [29:0]  memBackendAddress;
  logic [1:0]   memOffset;
  WriteEnable_t memWriteEnable;
  logic [31:0]  memStoreData;
  logic [31:0]  memDataOut;

  memory_access_sequencer #(.RAM_A_WIDTH(12)) dut (
    .clock             (clock),
    .reset             (reset),
    .reqValid          (reqValid),
    .reqReady          (reqReady),
    .reqIsStore        (reqIsStore),
    .reqFunct3         (reqFunct3),
    .reqAddress        (reqAddress),
    .reqStoreData      (reqStoreData),
    .loadData          (loadData),
    .done              (done),
    .fault             (fault),
    .memFunct3         (memFunct3),
    .memBackendAddress (memBackendAddress),
    .memOffset         (memOffset),
    .memWriteEnable    (memWriteEnable),
    .memStoreData      (memStoreData),
    .memDataOut        (memDataOut)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // RAM wrapper model: byte 0 is the most significant byte
  logic [31:0] mem [0:4095];
  logic [31:0] rdq;
  logic        initMem;

  function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] rs2, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] m;
    int sh;
    m = old;
    if (f3[1:0] == 2'b00) begin
      sh = (3 - int'(off)) * 8;
      m = (old & ~(32'hFF << sh)) | ((rs2 & 32'hFF) << sh);
    end else if (f3[1:0] == 2'b01) begin
      sh = off[1] ? 0 : 16;
      m = (old & ~(32'hFFFF << sh)) | ((rs2 & 32'hFFFF) << sh);
    end else begin
      m = rs2;
    end
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w,
      input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> ((3 - int'(off)) * 8));
    h = off[1] ? w[15:0] : w[31:16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clock) begin
    if (initMem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
      mem[8]  <= 32'h11223344;
      mem[12] <= 32'h80FF7F01;
      mem[16] <= 32'h01020304;
    end else begin
      rdq <= mem[memBackendAddress[11:0]];
      if (memWriteEnable == WE_ON)
        mem[memBackendAddress[11:0]] <=
          merge(mem[memBackendAddress[11:0]], memStoreData,
                memFunct3, memOffset);
    end
  end

  assign memDataOut = extract(rdq, memFunct3, memOffset);

  typedef struct {
    logic        st;
    logic        f;
    logic [31:0] d;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   weCnt = 0;
  int   busyCnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      weCnt = 0;
      busyCnt = 0;
    end else begin
      if (memWriteEnable == WE_ON) weCnt++;
      if (!reqReady) busyCnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("fault", 32'(fault), 32'(e.f));
          check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          check("we_cycles", 32'(weCnt), (e.st && !e.f) ? 32'd1 : 32'd0);
          check("busy_cycles", 32'(busyCnt), 32'(e.lat - 1));
          check("ready_at_done", 32'(reqReady), 32'd1);
          if (!e.st && !e.f) check("loadData", loadData, e.d);
        end
        weCnt = 0;
        busyCnt = 0;
      end else if (fault) begin
        check("fault_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] d,
      input logic expF, input logic [31:0] expD);
    exp_t e;
    logic rdy;
    int   acc;
    int   n;
    reqValid = 1'b1;
    reqIsStore = st;
    reqFunct3 = f3;
    reqAddress = a;
    reqStoreData = d;
    n = 0;
    forever begin
      rdy = reqReady;
      acc = cyc + 1;
      @(posedge clock);
      if (rdy || n >= 100) break;
      n++;
      #1;
    end
    #1;
    reqValid = 1'b0;
    if (!rdy) begin
      check("accept_timeout", 32'd1, 32'd0);
    end else begin
      e.st = st;
      e.f = expF;
      e.d = expD;
      e.lat = expF ? 1 : ((st && f3 == FUNCT3_W) ? 2 : 3);
      e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_ready"}, 32'(reqReady), 32'd1);
    check({p, "_done"}, 32'(done), 32'd0);
    check({p, "_fault"}, 32'(fault), 32'd0);
    check({p, "_we"}, 32'(memWriteEnable), 32'd0);
    check({p, "_loadData"}, loadData, 32'd0);
    check({p, "_addr"}, {memBackendAddress, memOffset}, 32'd0);
    check({p, "_funct3"}, 32'(memFunct3), 32'd0);
    check({p, "_storeData"}, memStoreData, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    initMem = 1'b1;
    reqValid = 1'b0;
    reqIsStore = 1'b0;
    reqFunct3 = 3'd0;
    reqAddress = 32'd0;
    reqStoreData = 32'd0;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    initMem = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    issue(1'b1, FUNCT3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    issue(1'b0, FUNCT3_W, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
    drain();

    issue(1'b1, FUNCT3_B, 32'h21, 32'h000000AA, 1'b0, 32'd0);
    issue(1'b0, FUNCT3_W, 32'h20, 32'd0, 1'b0, 32'h11AA3344);
    issue(1'b1, FUNCT3_H, 32'h22, 32'h0000BEEF, 1'b0, 32'd0);
    issue(1'b0, FUNCT3_HU, 32'h22, 32'd0, 1'b0, 32'h0000BEEF);
    issue(1'b0, FUNCT3_W, 32'h20, 32'd0, 1'b0, 32'h11AABEEF);
    drain();

    issue(1'b0, FUNCT3_B, 32'h30, 32'd0, 1'b0, 32'hFFFFFF80);
    issue(1'b0, FUNCT3_BU, 32'h30, 32'd0, 1'b0, 32'h00000080);
    issue(1'b0, FUNCT3_H, 32'h30, 32'd0, 1'b0, 32'hFFFF80FF);
    issue(1'b0, FUNCT3_HU, 32'h32, 32'd0, 1'b0, 32'h00007F01);
    issue(1'b0, FUNCT3_B, 32'h33, 32'd0, 1'b0, 32'h00000001);
    drain();

    issue(1'b0, FUNCT3_W, 32'h22, 32'd0, 1'b1, 32'd0);
    issue(1'b1, FUNCT3_H, 32'h23, 32'h1234, 1'b1, 32'd0);
    issue(1'b0, 3'b011, 32'h30, 32'd0, 1'b1, 32'd0);
    issue(1'b1, 3'b011, 32'h30, 32'hCAFEF00D, 1'b1, 32'd0);
    issue(1'b1, FUNCT3_W, 32'h4000, 32'hCAFEF00D, 1'b1, 32'd0);
    drain();
    check("mem_after_faults_20", mem[8], 32'h11AABEEF);
    check("mem_after_faults_30", mem[12], 32'h80FF7F01);
    check("mem_after_faults_0", mem[0], 32'd0);

    issue(1'b1, FUNCT3_W, 32'h50, 32'h12345678, 1'b0, 32'd0);
    issue(1'b0, FUNCT3_BU, 32'h51, 32'd0, 1'b0, 32'h00000034);
    issue(1'b1, FUNCT3_H, 32'h52, 32'hFFFFA5A5, 1'b0, 32'd0);
    issue(1'b0, FUNCT3_W, 32'h50, 32'd0, 1'b0, 32'h1234A5A5);
    drain();

    reqValid = 1'b1;
    reqIsStore = 1'b1;
    reqFunct3 = FUNCT3_B;
    reqAddress = 32'h40;
    reqStoreData = 32'h55;
    @(posedge clock);
    #1;
    reqValid = 1'b0;
    check("preload_we", 32'(memWriteEnable), 32'd0);
    check("preload_busy", 32'(reqReady), 32'd0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clock);
    check_reset_outputs("midrst_hold");
    reset = 1'b1;
    @(negedge clock);
    check("mem_after_reset", mem[16], 32'h01020304);
    issue(1'b0, FUNCT3_W, 32'h40, 32'd0, 1'b0, 32'h01020304);
    drain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
